transport_send: RTL and testbench

//  Transmit side of the transport layer: accepts 16-bit control words and audio samples from
//  the session layer, frames them into fixed PACKET_BYTES-byte packets, streams one byte per

---
 rtl/transport_send.sv | 168 ++++++++++++++++
 tb/tb_transport_send.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transport_send.sv
// Transport-layer transmitter: frames control words and audio sample blocks into fixed-size
// packets streamed one byte per cycle. S_IDLE | wait for pending work; S_HEADER | type byte;
// S_PAYLOAD | data bytes MSB first; S_PAD | zero fill to packet length.
module transport_send #(
  parameter int PACKET_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sendType,
  input  logic [15:0] dataIn,
  input  logic        netReady,
  output logic        busy,
  output logic        sendSignal,
  output logic [7:0]  packetOut,
  output logic [7:0]  dropCount
);
  localparam int SPP = (PACKET_BYTES - 2) / 2;
  localparam int CW  = $clog2(PACKET_BYTES);
  localparam int WW  = $clog2(SPP + 1);
  localparam logic [CW-1:0] CTRL_PAY_LAST = CW'(1);
  localparam logic [CW-1:0] AUD_PAY_LAST  = CW'(2 * SPP - 1);
  localparam logic [CW-1:0] CTRL_PAD_LAST = CW'(PACKET_BYTES - 4);
  localparam logic [CW-1:0] AUD_PAD_LAST  = CW'(PACKET_BYTES - 2 - 2 * SPP);
  localparam bit CTRL_PAD_NONE = (PACKET_BYTES - 3) == 0;
  localparam bit AUD_PAD_NONE  = (PACKET_BYTES - 1 - 2 * SPP) == 0;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PAD} state_t;
  state_t state, state_nx;

  logic          is_audio;
  logic [15:0]   ctrl_word, tx_word, rd_sample;
  logic [CW-1:0] byte_cnt, pay_idx;
  logic [7:0]    pay_byte;
  logic [15:0]   bank_mem [2][SPP];
  logic [1:0]    bank_full, full_nx;
  logic          coll_bank, coll_bank_nx, coll_valid, coll_valid_nx, rd_bank, rd_bank_nx;
  logic [WW-1:0] wr_idx, wr_idx_nx, samp_idx;
  logic          launch, ctrl_take, aud_write, aud_free, drop, pad_none;

  assign launch    = (state == S_IDLE) && netReady && (busy || bank_full[rd_bank]);
  assign ctrl_take = launch && busy;
  assign aud_write = (sendType == 2'b10) && coll_valid;
  assign aud_free  = (state == S_PAYLOAD) && is_audio && (byte_cnt == '0);
  assign drop      = ((sendType == 2'b01) && busy && !ctrl_take) ||
                     ((sendType == 2'b10) && !coll_valid);
  assign pad_none  = is_audio ? AUD_PAD_NONE : CTRL_PAD_NONE;

  assign samp_idx  = WW'(pay_idx >> 1);
  assign rd_sample = bank_mem[rd_bank][samp_idx];
  assign pay_byte  = is_audio ? (pay_idx[0] ? rd_sample[7:0] : rd_sample[15:8])
                              : (pay_idx[0] ? tx_word[7:0]   : tx_word[15:8]);

  always_comb begin
    state_nx   = state;
    sendSignal = 1'b0;
    packetOut  = 8'h00;
    case (state)
      S_IDLE:    if (launch) state_nx = S_HEADER;
      S_HEADER: begin
        sendSignal = 1'b1;
        packetOut  = is_audio ? 8'h80 : 8'h40;
        state_nx   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        sendSignal = 1'b1;
        packetOut  = pay_byte;
        if (byte_cnt == '0) state_nx = pad_none ? S_IDLE : S_PAD;
      end
      S_PAD: begin
        sendSignal = 1'b1;
        if (byte_cnt == '0) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      is_audio <= 1'b0;
      tx_word  <= '0;
      byte_cnt <= '0;
      pay_idx  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (launch) begin
          is_audio <= !busy;
          if (busy) tx_word <= ctrl_word;
        end
        S_HEADER: begin
          byte_cnt <= is_audio ? AUD_PAY_LAST : CTRL_PAY_LAST;
          pay_idx  <= '0;
        end
        S_PAYLOAD: begin
          pay_idx  <= pay_idx + CW'(1);
          byte_cnt <= (byte_cnt == '0) ? (is_audio ? AUD_PAD_LAST : CTRL_PAD_LAST)
                                       : byte_cnt - CW'(1);
        end
        default: byte_cnt <= byte_cnt - CW'(1);
      endcase
    end
  end

  // A control word arriving while the held one launches replaces it without a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      ctrl_word <= '0;
      dropCount <= '0;
    end else begin
      if ((sendType == 2'b01) && (!busy || ctrl_take)) begin
        ctrl_word <= dataIn;
        busy      <= 1'b1;
      end else if (ctrl_take) begin
        busy <= 1'b0;
      end
      if (drop && (dropCount != 8'hFF)) dropCount <= dropCount + 8'd1;
    end
  end

  // Banks fill and drain in strict alternation, so rd_bank always names the oldest ready bank.
  always_comb begin
    full_nx       = bank_full;
    coll_bank_nx  = coll_bank;
    coll_valid_nx = coll_valid;
    wr_idx_nx     = wr_idx;
    rd_bank_nx    = rd_bank;
    if (aud_write) begin
      if (wr_idx == WW'(SPP - 1)) begin
        wr_idx_nx          = '0;
        full_nx[coll_bank] = 1'b1;
        if (!bank_full[~coll_bank]) coll_bank_nx  = ~coll_bank;
        else                        coll_valid_nx = 1'b0;
      end else begin
        wr_idx_nx = wr_idx + WW'(1);
      end
    end
    if (aud_free) begin
      full_nx[rd_bank] = 1'b0;
      rd_bank_nx       = ~rd_bank;
      if (!coll_valid_nx) begin
        coll_valid_nx = 1'b1;
        coll_bank_nx  = rd_bank;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full  <= '0;
      coll_bank  <= 1'b0;
      coll_valid <= 1'b1;
      wr_idx     <= '0;
      rd_bank    <= 1'b0;
    end else begin
      bank_full  <= full_nx;
      coll_bank  <= coll_bank_nx;
      coll_valid <= coll_valid_nx;
      wr_idx     <= wr_idx_nx;
      rd_bank    <= rd_bank_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (aud_write) bank_mem[coll_bank][wr_idx] <= dataIn;
  end
endmodule

// File: tb/tb_transport_send.sv
// Bench for transport_send: a table-driven control packet, directed multi-cycle sequences and
// random traffic, all compared cycle by cycle with a queue-based packet model.
module tb_transport_send;
  localparam int PB  = 16;
  localparam int SPP = (PB - 2) / 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sendType;
  logic [15:0] dataIn;
  logic        netReady;
  logic        busy, sendSignal;
  logic [7:0]  packetOut, dropCount;

  transport_send #(.PACKET_BYTES(PB)) dut (
    .clk(clk), .reset(reset), .sendType(sendType), .dataIn(dataIn), .netReady(netReady),
    .busy(busy), .sendSignal(sendSignal), .packetOut(packetOut), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending control word, complete sample blocks, partial block, byte stream.
  bit          m_pend;
  logic [15:0] m_word;
  int          m_drop;
  logic [15:0] m_ready[$];
  logic [15:0] m_coll[$];
  logic [7:0]  m_tx[$];
  int          m_pos;
  bit          m_hold;
  logic [7:0]  got_q[$];

  typedef struct {
    logic [1:0]  st;
    logic [15:0] d;
    logic        nr;
    logic        ss;
    logic [7:0]  po;
    logic        bz;
    logic [7:0]  dc;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_word = '0; m_drop = 0; m_pos = 0; m_hold = 0;
    m_ready.delete(); m_coll.delete(); m_tx.delete();
  endtask

  task automatic model_edge(input logic [1:0] st, input logic [15:0] d, input logic nr);
    int occ;
    bit tx_empty, launch, dropped;
    logic [15:0] s;
    occ      = m_ready.size() / SPP + int'(m_hold);
    tx_empty = (m_tx.size() == 0);
    launch   = tx_empty && nr && (m_pend || m_ready.size() >= SPP);
    dropped  = 0;
    if (!tx_empty) begin
      if (m_hold && m_pos == 2 * SPP) m_hold = 0;
      void'(m_tx.pop_front());
      m_pos++;
    end
    if (launch) begin
      m_pos = 0;
      if (m_pend) begin
        m_tx.push_back(8'h40); m_tx.push_back(m_word[15:8]); m_tx.push_back(m_word[7:0]);
        m_pend = 0;
      end else begin
        m_tx.push_back(8'h80);
        for (int k = 0; k < SPP; k++) begin
          s = m_ready.pop_front();
          m_tx.push_back(s[15:8]); m_tx.push_back(s[7:0]);
        end
        m_hold = 1;
      end
      while (m_tx.size() < PB) m_tx.push_back(8'h00);
    end
    if (st == 2'b01) begin
      if (!m_pend) begin m_pend = 1; m_word = d; end
      else dropped = 1;
    end else if (st == 2'b10) begin
      if (occ < 2) begin
        m_coll.push_back(d);
        if (m_coll.size() == SPP) begin
          foreach (m_coll[k]) m_ready.push_back(m_coll[k]);
          m_coll.delete();
        end
      end else dropped = 1;
    end
    if (dropped && m_drop < 255) m_drop++;
  endtask

  task automatic step(input logic [1:0] st, input logic [15:0] d, input logic nr);
    logic [7:0] exp_po;
    sendType = st; dataIn = d; netReady = nr;
    model_edge(st, d, nr);
    @(posedge clk);
    #1;
    exp_po = 8'h00;
    if (m_tx.size() > 0) exp_po = m_tx[0];
    chk("sendSignal", 32'(sendSignal), 32'(m_tx.size() > 0));
    chk("packetOut", 32'(packetOut), 32'(exp_po));
    chk("busy", 32'(busy), 32'(m_pend));
    chk("dropCount", 32'(dropCount), 32'(m_drop));
    if (sendSignal) got_q.push_back(packetOut);
  endtask

  task automatic do_reset();
    reset = 1'b1; sendType = 2'b00; dataIn = '0; netReady = 1'b0;
    model_reset();
    got_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic nr);
    for (int k = 0; k < n; k++) step(2'b00, 16'h0000, nr);
  endtask

  initial begin
    logic [15:0] s;
    logic [7:0]  e;
    int          bias;

    tbl[0] = '{2'b01, 16'hA55A, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[1] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00};
    tbl[2] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[3] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00};
    for (int i = 4; i < 17; i++) tbl[i] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[17] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};

    // Reset state
    do_reset();
    chk("rst_sendSignal", 32'(sendSignal), 0);
    chk("rst_packetOut", 32'(packetOut), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dropCount", 32'(dropCount), 0);

    // Control packet from the vector table
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].st, tbl[i].d, tbl[i].nr);
      chk($sformatf("t1_sendSignal[%0d]", i), 32'(sendSignal), 32'(tbl[i].ss));
      chk($sformatf("t1_packetOut[%0d]", i), 32'(packetOut), 32'(tbl[i].po));
      chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("t1_dropCount[%0d]", i), 32'(dropCount), 32'(tbl[i].dc));
    end

    // Audio packet: bytes 01..0E
    do_reset();
    for (int i = 0; i < SPP; i++) step(2'b10, {8'(2 * i + 1), 8'(2 * i + 2)}, 1'b0);
    idle_cycles(20, 1'b1);
    chk("t2_len", 32'(got_q.size()), 32'(PB));
    for (int j = 0; j < got_q.size() && j < PB; j++) begin
      e = (j == 0) ? 8'h80 : (j <= 2 * SPP) ? 8'(j) : 8'h00;
      chk($sformatf("t2_byte[%0d]", j), 32'(got_q[j]), 32'(e));
    end

    // Control pending wins over a ready audio bank
    do_reset();
    for (int i = 0; i < SPP; i++) step(2'b10, 16'(i * 16'h1111 + 1), 1'b0);
    step(2'b01, 16'hBEEF, 1'b0);
    idle_cycles(40, 1'b1);
    chk("t3_len", 32'(got_q.size()), 32'(2 * PB));
    if (got_q.size() == 2 * PB) begin
      chk("t3_hdr0", 32'(got_q[0]), 32'h40);
      chk("t3_word_hi", 32'(got_q[1]), 32'hBE);
      chk("t3_word_lo", 32'(got_q[2]), 32'hEF);
      chk("t3_hdr1", 32'(got_q[PB]), 32'h80);
      chk("t3_samp0_lo", 32'(got_q[PB + 2]), 32'h01);
    end

    // Both banks full: third block dropped, then two audio packets in order
    do_reset();
    for (int i = 0; i < 3 * SPP; i++) step(2'b10, 16'(i * 257 + 3), 1'b0);
    chk("t4_drops", 32'(dropCount), 7);
    idle_cycles(60, 1'b1);
    chk("t4_len", 32'(got_q.size()), 32'(2 * PB));
    if (got_q.size() == 2 * PB) begin
      chk("t4_hdr0", 32'(got_q[0]), 32'h80);
      chk("t4_hdr1", 32'(got_q[PB]), 32'h80);
      s = 16'(0 * 257 + 3);
      chk("t4_first_samp", 32'({got_q[1], got_q[2]}), 32'(s));
      s = 16'(SPP * 257 + 3);
      chk("t4_second_samp", 32'({got_q[PB + 1], got_q[PB + 2]}), 32'(s));
    end

    // Back-to-back control words while network is not ready
    do_reset();
    step(2'b01, 16'h1234, 1'b0);
    step(2'b01, 16'h5678, 1'b0);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_drops", 32'(dropCount), 1);
    idle_cycles(20, 1'b1);
    chk("t5_len", 32'(got_q.size()), 32'(PB));
    if (got_q.size() == PB) begin
      chk("t5_word_hi", 32'(got_q[1]), 32'h12);
      chk("t5_word_lo", 32'(got_q[2]), 32'h34);
    end

    // Reset in the middle of an audio packet with a second bank waiting
    do_reset();
    for (int i = 0; i < 2 * SPP; i++) step(2'b10, 16'(i + 16'h0A00), 1'b0);
    for (int k = 0; k < 30 && got_q.size() < 5; k++) step(2'b00, 16'h0000, 1'b1);
    chk("t6_reach_byte5", 32'(got_q.size()), 5);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_sendSignal", 32'(sendSignal), 0);
    chk("t6_packetOut", 32'(packetOut), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_dropCount", 32'(dropCount), 0);
    #1 reset = 1'b0;
    got_q.delete();
    idle_cycles(30, 1'b1);
    chk("t6_banks_empty", 32'(got_q.size()), 0);
    for (int i = 0; i < SPP; i++) step(2'b10, 16'(i + 16'h7700), 1'b1);
    idle_cycles(25, 1'b1);
    chk("t6_fresh_len", 32'(got_q.size()), 32'(PB));

    // Random traffic with varying network availability
    do_reset();
    bias = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) bias = int'($urandom_range(0, 4));
      step(2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 3) < bias));
    end

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) step(2'b01, 16'(i), 1'b0);
    chk("sat_dropCount", 32'(dropCount), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
